// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
package mod_counter_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Loads at or above the modulus clamp to the top of the count range.
    function automatic logic [63:0] clamp_load(input logic [63:0] val, input logic [63:0] modulus);
        if (val >= modulus) begin
            return modulus - 64'd1;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count, wrap-event and bound-hit logic for mod_counter.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH = 4,
    parameter longint MOD   = 16
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap,
    output logic             o_hit
);

    // Bounds are compared one bit wider so MOD = 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MAX_C = (WIDTH+1)'(MOD - 64'sd1);
    localparam logic [WIDTH-1:0] MAX_W = MAX_C[WIDTH-1:0];

    logic [WIDTH:0] w_cnt_ext;
    logic           w_at_max;
    logic           w_at_zero;

    assign w_cnt_ext = {1'b0, i_count};
    assign w_at_max  = (w_cnt_ext == MAX_C);
    assign w_at_zero = (w_cnt_ext == {(WIDTH+1){1'b0}});

    // Step one position in the selected direction, handling both bounds.
    always_comb begin
        o_next = i_count;
        o_wrap = 1'b0;
        o_hit  = 1'b0;
        if (i_up == DIR_UP) begin
            if (w_at_max) begin
                o_hit = 1'b1;
                if (i_sat == MODE_WRAP) begin
                    o_next = {WIDTH{1'b0}};
                    o_wrap = 1'b1;
                end else begin
                    o_next = i_count;
                end
            end else begin
                o_next = i_count + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            if (w_at_zero) begin
                o_hit = 1'b1;
                if (i_sat == MODE_WRAP) begin
                    o_next = MAX_W;
                    o_wrap = 1'b1;
                end else begin
                    o_next = i_count;
                end
            end else begin
                o_next = i_count - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with wrap/saturate modes and sticky overflow.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH = 4,
    parameter longint MOD   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > 32 || MOD < 64'sd2 || MOD > (64'sd1 << WIDTH)) begin : g_bad_params
        $fatal(1, "mod_counter: illegal WIDTH=%0d / MOD=%0d", WIDTH, MOD);
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_next;
    logic             w_wrap_evt;
    logic             w_hit;
    logic [WIDTH-1:0] w_count_d;
    logic             w_wrap_d;
    logic             w_ovf_d;

    mod_counter_next #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .i_count (r_count),
        .i_up    (up),
        .i_sat   (sat),
        .o_next  (w_next),
        .o_wrap  (w_wrap_evt),
        .o_hit   (w_hit)
    );

    // Priority mux: clear beats load beats counting; an overflow set beats clr_ovf.
    always_comb begin
        w_count_d = r_count;
        w_wrap_d  = 1'b0;
        w_ovf_d   = r_ovf;
        if (clr) begin
            w_count_d = {WIDTH{1'b0}};
        end else if (load) begin
            w_count_d = WIDTH'(clamp_load(64'(load_val), 64'(MOD)));
        end else if (en) begin
            w_count_d = w_next;
            w_wrap_d  = w_wrap_evt;
        end else begin
            w_count_d = r_count;
        end
        if (!clr && !load && en && w_hit) begin
            w_ovf_d = 1'b1;
        end else if (clr_ovf) begin
            w_ovf_d = 1'b0;
        end else begin
            w_ovf_d = r_ovf;
        end
    end

    // State registers update on the falling clock edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {WIDTH{1'b0}};
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_wrap  <= w_wrap_d;
            r_ovf   <= w_ovf_d;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;
    assign tc    = en & w_hit;

endmodule

// File: tb/tb_mod_counter.sv
// Directed scoreboard bench for mod_counter (MOD = 10 and full-range MOD = 16).
module tb_mod_counter;

    logic       clk;
    logic       reset;
    logic       en, up, sat, clr, load, clr_ovf;
    logic [3:0] load_val;

    logic [3:0] count10, count16;
    logic       tc10, wrap10, ovf10;
    logic       tc16, wrap16, ovf16;

    int n_tests;
    int n_fail;

    typedef struct {
        string      tag;
        logic       sel;
        logic [3:0] c;
        logic       w;
        logic       o;
        logic       t;
    } exp_t;

    exp_t sb[$];

    mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .count(count10), .tc(tc10), .wrap(wrap10), .ovf(ovf10)
    );

    mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .count(count16), .tc(tc16), .wrap(wrap16), .ovf(ovf16)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (e.sel) begin
                cmp(e.tag, "count", count16, e.c);
                cmp(e.tag, "wrap", {3'b000, wrap16}, {3'b000, e.w});
                cmp(e.tag, "ovf", {3'b000, ovf16}, {3'b000, e.o});
                cmp(e.tag, "tc", {3'b000, tc16}, {3'b000, e.t});
            end else begin
                cmp(e.tag, "count", count10, e.c);
                cmp(e.tag, "wrap", {3'b000, wrap10}, {3'b000, e.w});
                cmp(e.tag, "ovf", {3'b000, ovf10}, {3'b000, e.o});
                cmp(e.tag, "tc", {3'b000, tc10}, {3'b000, e.t});
            end
        end
    endtask

    task automatic push(input string tag, input logic sel, input logic [3:0] c,
                        input logic w, input logic o, input logic t);
        exp_t e;
        e.tag = tag; e.sel = sel; e.c = c; e.w = w; e.o = o; e.t = t;
        sb.push_back(e);
    endtask

    task automatic expect_edge(input string tag, input logic sel, input logic [3:0] c,
                               input logic w, input logic o, input logic t);
        push(tag, sel, c, w, o, t);
        @(negedge clk);
        #1;
        check_front();
    endtask

    task automatic expect_now(input string tag, input logic sel, input logic [3:0] c,
                              input logic w, input logic o, input logic t);
        push(tag, sel, c, w, o, t);
        check_front();
    endtask

    initial begin
        logic [3:0] c;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        expect_now("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        en = 1'b1; up = 1'b1; sat = 1'b0;
        expect_now("start", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 1; i <= 12; i++) begin
            c = 4'(i % 10);
            expect_edge($sformatf("up_wrap%0d", i), 1'b0, c, (i == 10), (i >= 10), (c == 4'd9));
        end

        en = 1'b0; load = 1'b1; load_val = 4'd3; clr_ovf = 1'b1;
        expect_edge("load3", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        load = 1'b0; clr_ovf = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b1;
        expect_edge("dn_sat1", 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_edge("dn_sat2", 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_edge("dn_sat3", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_edge("dn_sat4", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        expect_edge("dn_sat5", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        expect_edge("dn_sat6", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

        en = 1'b0; load = 1'b1; load_val = 4'd12;
        expect_edge("load_clamp", 1'b0, 4'd9, 1'b0, 1'b1, 1'b0);
        clr = 1'b1; load_val = 4'd5;
        expect_edge("clr_over_load", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        clr = 1'b0; load_val = 4'd7;
        expect_edge("load7", 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        expect_edge("hold1", 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
        expect_edge("hold2", 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);

        load = 1'b1; load_val = 4'd8; clr_ovf = 1'b1;
        expect_edge("load8_clrovf", 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
        load = 1'b0; clr_ovf = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        expect_edge("race_to9", 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
        clr_ovf = 1'b1;
        expect_edge("race_wrap", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        expect_edge("clr_ovf_alone", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        load = 1'b1; load_val = 4'd9;
        expect_edge("load9", 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
        expect_edge("up_sat_hold", 1'b0, 4'd9, 1'b0, 1'b1, 1'b1);

        clr = 1'b1; sat = 1'b0;
        expect_edge("clr_keeps_ovf", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        clr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            expect_edge($sformatf("pre_rst%0d", i), 1'b0, 4'(i), 1'b0, 1'b1, 1'b0);
        end
        #2;
        reset = 1'b0;
        #1;
        expect_now("async_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_edge("rst_held", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_edge($sformatf("resume%0d", i), 1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
        end

        reset = 1'b0;
        #1;
        expect_now("rst16", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            c = 4'(i % 16);
            expect_edge($sformatf("full%0d", i), 1'b1, c, (i == 16), (i >= 16), (c == 4'd15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter; next-generation replacement for the fixed 4-bit wrap counter. Adds configurable width and modulus, direction control, count enable, synchronous load and clear, wrap vs. saturate mode, terminal-count and wrap outputs, and a sticky overflow flag. Sits in timing/sequencing datapaths as the standard event and interval counter.

## Interface
- WIDTH, 4: count width in bits; legal range 2..32.
- MOD, 16: modulus; count range 0..MOD-1; legal range 2..2**WIDTH.
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction; 1 = increment, 0 = decrement.
- sat  in  1  mode; 0 = wrap at the bounds, 1 = saturate at the bounds.
- clr  in  1  synchronous clear of count to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- clr_ovf  in  1  synchronous clear of ovf.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational.
- wrap  out  1  one-cycle registered pulse on a wrap event.
- ovf  out  1  sticky overflow flag, registered.

## Operation
- Reset low:
  - count = 0, wrap = 0, ovf = 0 immediately, independent of clk.
  - Applies mid-operation; it overrides every other input.
- Priority per falling edge: clr > load > en count > hold.
- clr: count <= 0; wrap <= 0; ovf is unaffected.
- load:
  - count <= load_val.
  - If load_val >= MOD, count <= MOD-1 (clamp); no ovf.
  - wrap <= 0.
- en with up = 1:
  - If count < MOD-1: count + 1.
  - If count == MOD-1 and sat = 0: count <= 0, wrap <= 1, ovf <= 1.
  - If count == MOD-1 and sat = 1: hold, wrap <= 0, ovf <= 1.
- en with up = 0:
  - If count > 0: count - 1.
  - If count == 0 and sat = 0: count <= MOD-1, wrap <= 1, ovf <= 1.
  - If count == 0 and sat = 1: hold, ovf <= 1.
- en = 0 with no clr or load: hold; wrap <= 0.
- tc = en & (up ? count == MOD-1 : count == 0). It flags that the next enabled edge hits a bound.
- ovf:
  - Set when an enabled count is attempted at a bound (wrap or saturate).
  - Cleared by clr_ovf.
  - If set and clr_ovf occur on the same edge, set wins.
- Arithmetic: comparisons are done at WIDTH+1 bits, so MOD = 2**WIDTH does not overflow. Count never leaves 0..MOD-1.
- Changing up or sat between edges is legal; each edge uses the values present at that edge.

## Timing
- Latency: count, wrap and ovf update on the falling edge after the inputs are sampled. tc follows count and en combinationally.
- wrap is high for exactly one clk period after the wrap edge.
- Back-to-back wraps (MOD = 2 with en held) give wrap high every other period.
- Reset deassertion must meet recovery/removal timing relative to the falling edge. The first count occurs on the first falling edge after deassertion.
- No multi-cycle paths; single clock domain.

## Structure
- Package mod_counter_pkg:
  - direction constants DIR_UP / DIR_DN.
  - mode constants MODE_WRAP / MODE_SAT.
  - a function computing the clamped load value.
- One sub-module, mod_counter_next: combinational next-count, wrap-event and bound-hit logic. The top keeps the registers, the priority mux and the ovf flag.
- Parameter legality is checked at elaboration; illegal WIDTH/MOD is a fatal error.

## Test plan
- WIDTH = 4, MOD = 10, reset low for 2 cycles, then en = 1, up = 1, sat = 0 for 12 edges:
  - count 0..9, then 0, 1.
  - wrap high only after the 9->0 edge; ovf = 1 thereafter.
  - tc high while count = 9.
- Down, saturate: load 3, then up = 0, sat = 1, en = 1 for 6 edges:
  - count 3, 2, 1, 0, 0, 0.
  - wrap never asserts; ovf sets on the first hold at 0.
- Load clamp and priority:
  - load_val = 12 -> count = 9.
  - clr and load on the same edge -> count = 0.
  - en = 0 -> count holds.
- ovf race: assert clr_ovf on the same edge as a 9->0 wrap -> ovf stays 1. Then clr_ovf alone -> ovf = 0.
- Reset mid-count: at count = 5, pull reset low between falling edges:
  - count, wrap and ovf go to 0 immediately.
  - After release, counting resumes 1, 2, ...
- Full range: WIDTH = 4, MOD = 16, up = 1, wrap mode -> 15->0 wrap with wrap pulse; no width overflow or X.
